// File: rtl/pwm_duty_slew_if.sv
// Target-duty handshake bundle between a duty requester and the slew limiter.
interface pwm_duty_slew_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             target_ready;

  modport master (
    output target,
    output target_valid,
    input  target_ready
  );

  modport slave (
    input  target,
    input  target_valid,
    output target_ready
  );
endinterface

// File: rtl/pwm_duty_slew.sv
// Duty-cycle slew limiter: walks the applied PWM duty toward a requested target
// in steps of at most STEP, only on every DIV-th PWM period boundary.
module pwm_duty_slew #(
  parameter int WIDTH = 8,
  parameter int STEP  = 4,
  parameter int DIV   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              period_end,
  pwm_duty_slew_if.slave    tgt_if,
  output logic [WIDTH-1:0]  duty,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]        DIV_LAST = CNT_W'(DIV - 1);
  localparam logic signed [WIDTH+1:0] MAX_S    = (WIDTH+2)'((1 << WIDTH) - 1);
  localparam logic signed [WIDTH+1:0] STEP_S   = (WIDTH+2)'(STEP);
  localparam logic signed [WIDTH:0]   STEP_N   = (WIDTH+1)'(STEP);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   duty_q, duty_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic               done_q, done_d;

  logic               accept;
  logic               qual;
  logic               upd;
  logic [WIDTH-1:0]   step_duty;

  function automatic logic [WIDTH-1:0] sat_duty(input logic signed [WIDTH+1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_S)
      return {WIDTH{1'b1}};
    else
      return v[WIDTH-1:0];
  endfunction

  // Difference is taken one bit wider than the duty so large moves never wrap.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = (diff < 0) ? -diff : diff;
    if (mag <= STEP_N)
      return tgt;
    else if (diff > 0)
      return sat_duty($signed({2'b00, cur}) + STEP_S);
    else
      return sat_duty($signed({2'b00, cur}) - STEP_S);
  endfunction

  assign accept    = tgt_if.target_valid & tgt_if.target_ready;
  assign qual      = ena & period_end & (state_q == RAMP);
  assign upd       = qual & (div_cnt_q == DIV_LAST);
  assign step_duty = step_toward(duty_q, tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      tgt_q     <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      tgt_q     <= tgt_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RAMP;
      RAMP:    if (upd && (step_duty == tgt_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Period-boundary divider and duty step; ena gating lives in accept/qual.
  always_comb begin
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    if (accept) begin
      tgt_d     = tgt_if.target;
      div_cnt_d = '0;
    end else if (qual) begin
      if (upd) begin
        div_cnt_d = '0;
        duty_d    = step_duty;
        done_d    = (step_duty == tgt_q);
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    tgt_if.target_ready = ena & (state_q == IDLE);
    busy                = (state_q == RAMP);
    done                = done_q;
    duty                = duty_q;
  end

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Directed bench for pwm_duty_slew with WIDTH=8, STEP=4, DIV=2.
module tb_pwm_duty_slew;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic             period_end = 1'b0;
  logic [WIDTH-1:0] duty;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  pwm_duty_slew_if #(.WIDTH(WIDTH)) tif ();

  pwm_duty_slew #(.WIDTH(WIDTH), .STEP(4), .DIV(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .period_end (period_end),
    .tgt_if     (tif.slave),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pe(input int gap);
    repeat (gap) tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic accept(input logic [WIDTH-1:0] v, input logic with_pe);
    tif.target       = v;
    tif.target_valid = 1'b1;
    period_end       = with_pe;
    tick();
    tif.target_valid = 1'b0;
    period_end       = 1'b0;
  endtask

  task automatic test_reset();
    tif.target = '0;
    tif.target_valid = 1'b0;
    #2;
    checks++; if (duty !== 8'd0) begin errors++; $display("FAIL reset_duty got %0d exp 0", duty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (tif.target_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", tif.target_ready); end
    #10 rst_n = 1'b1;
    tick();
    tick();
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL reset_exit_done got %0d exp 0", done_seen); end
  endtask

  task automatic test_ramp_up();
    int d0;
    d0 = done_seen;
    accept(8'd100, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy got %b exp 1", busy); end
    checks++; if (tif.target_ready !== 1'b0) begin errors++; $display("FAIL up_ready got %b exp 0", tif.target_ready); end
    for (int k = 1; k <= 50; k++) begin
      pe(255);
      checks++;
      if (duty !== 8'((k / 2) * 4)) begin errors++; $display("FAIL up_duty pe=%0d got %0d exp %0d", k, duty, (k / 2) * 4); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL up_done got %b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_end got %b exp 0", busy); end
    checks++; if (tif.target_ready !== 1'b1) begin errors++; $display("FAIL up_ready_end got %b exp 1", tif.target_ready); end
    tick();
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL up_done_count got %0d exp 1", done_seen - d0); end
  endtask

  task automatic test_ramp_down();
    int d0;
    int exp_d;
    d0 = done_seen;
    accept(8'd2, 1'b0);
    for (int j = 1; j <= 25; j++) begin
      pe(7);
      checks++; if (duty !== 8'd100 - 8'(4 * (j - 1))) begin errors++; $display("FAIL down_hold j=%0d got %0d", j, duty); end
      pe(7);
      exp_d = (j < 25) ? 100 - 4 * j : 2;
      checks++; if (duty !== 8'(exp_d)) begin errors++; $display("FAIL down_duty j=%0d got %0d exp %0d", j, duty, exp_d); end
    end
    tick();
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL down_done_count got %0d exp 1", done_seen - d0); end
  endtask

  task automatic test_equal_target();
    accept(8'd2, 1'b0);
    pe(3);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL eq_mid got busy=%b done=%b exp 1 0", busy, done); end
    pe(3);
    checks++; if (done !== 1'b1 || duty !== 8'd2) begin errors++; $display("FAIL eq_done got done=%b duty=%0d exp 1 2", done, duty); end
  endtask

  task automatic test_top_clamp();
    accept(8'd251, 1'b0);
    for (int j = 0; j < 63; j++) begin pe(1); pe(1); end
    checks++; if (duty !== 8'd251) begin errors++; $display("FAIL clamp_setup got %0d exp 251", duty); end
    accept(8'd255, 1'b0);
    pe(2);
    pe(2);
    checks++; if (duty !== 8'd255) begin errors++; $display("FAIL clamp_duty got %0d exp 255", duty); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clamp_done got %b exp 1", done); end
  endtask

  task automatic test_back_to_back();
    accept(8'd247, 1'b0);
    tif.target = 8'd10;
    tif.target_valid = 1'b1;
    pe(2);
    checks++; if (tif.target_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b exp 0", tif.target_ready); end
    pe(2);
    checks++; if (duty !== 8'd251) begin errors++; $display("FAIL b2b_step1 got %0d exp 251", duty); end
    pe(2);
    pe(2);
    checks++; if (duty !== 8'd247 || done !== 1'b1) begin errors++; $display("FAIL b2b_step2 got duty=%0d done=%b exp 247 1", duty, done); end
    tick();
    tif.target_valid = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_reaccept got busy=%b done=%b exp 1 0", busy, done); end
  endtask

  task automatic test_ena_freeze();
    pe(2);
    ena = 1'b0;
    tick();
    checks++; if (tif.target_ready !== 1'b0) begin errors++; $display("FAIL ena_ready got %b exp 0", tif.target_ready); end
    repeat (3) pe(2);
    checks++; if (duty !== 8'd247 || busy !== 1'b1) begin errors++; $display("FAIL ena_hold got duty=%0d busy=%b exp 247 1", duty, busy); end
    ena = 1'b1;
    pe(2);
    checks++; if (duty !== 8'd243) begin errors++; $display("FAIL ena_resume got %0d exp 243", duty); end
    pe(2);
    checks++; if (duty !== 8'd243) begin errors++; $display("FAIL ena_spacing got %0d exp 243", duty); end
    pe(2);
    checks++; if (duty !== 8'd239) begin errors++; $display("FAIL ena_step got %0d exp 239", duty); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_seen;
    pe(2);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (duty !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst got duty=%0d busy=%b exp 0 0", duty, busy); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checks++; if (tif.target_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", tif.target_ready); end
    pe(2);
    pe(2);
    checks++; if (duty !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_pe got duty=%0d busy=%b exp 0 0", duty, busy); end
    checks++; if (done_seen !== d0) begin errors++; $display("FAIL mid_rst_done got %0d exp %0d", done_seen, d0); end
    accept(8'd3, 1'b1);
    pe(2);
    checks++; if (duty !== 8'd0) begin errors++; $display("FAIL acc_pe_ignored got %0d exp 0", duty); end
    pe(2);
    checks++; if (duty !== 8'd3 || done !== 1'b1) begin errors++; $display("FAIL acc_pe_step got duty=%0d done=%b exp 3 1", duty, done); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_equal_target();
    test_top_clamp();
    test_back_to_back();
    test_ena_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
